// File: rtl/cordic_gain_accum.sv
// CORDIC scale-factor generator: K(N) = prod_{i<N} cos(atan(2^-i)) in IEEE-754 single.
// Each request selects N at run time. The product is accumulated one factor per clock
// through the team's combinational Floating_Point_Multiplier.
// Optional build macro GAIN_UNITY_SKIP_EN ends the run early once every remaining
// factor is exactly 1.0. The result is unchanged; only the latency shortens.

// Combinational single-precision multiplier, round-to-nearest-even.
// Denormal inputs and results are flushed to zero.
module Floating_Point_Multiplier (
   output logic [31:0] out,
   input  logic [31:0] a,
   input  logic [31:0] b
);

   logic              sign;
   logic [7:0]        exp_a;
   logic [7:0]        exp_b;
   logic [23:0]       mant_a;
   logic [23:0]       mant_b;
   logic [47:0]       product;
   logic signed [9:0] exp_sum;
   logic [22:0]       frac;
   logic              guard_bit;
   logic              sticky_bit;
   logic [23:0]       rounded;

   // Normalise the 48-bit significand product, round to nearest-even, then resolve
   // special operands and exponent range.
   always_comb begin
      sign       = a[31] ^ b[31];
      exp_a      = a[30:23];
      exp_b      = b[30:23];
      mant_a     = {1'b1, a[22:0]};
      mant_b     = {1'b1, b[22:0]};
      product    = 48'(mant_a) * 48'(mant_b);
      exp_sum    = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
      frac       = product[45:23];
      guard_bit  = product[22];
      sticky_bit = |product[21:0];
      if (product[47]) begin
         frac       = product[46:24];
         guard_bit  = product[23];
         sticky_bit = |product[22:0];
         exp_sum    = exp_sum + 10'sd1;
      end
      rounded = {1'b0, frac} + 24'(guard_bit & (sticky_bit | frac[0]));
      if (rounded[23]) begin
         exp_sum = exp_sum + 10'sd1;
      end
      out = {sign, exp_sum[7:0], rounded[22:0]};
      if (exp_a == 8'hFF || exp_b == 8'hFF) begin
         if ((exp_a == 8'hFF && a[22:0] != 23'd0) || (exp_b == 8'hFF && b[22:0] != 23'd0) ||
             exp_a == 8'h00 || exp_b == 8'h00) begin
            out = 32'h7FC00000;
         end else begin
            out = {sign, 8'hFF, 23'd0};
         end
      end else if (exp_a == 8'h00 || exp_b == 8'h00) begin
         out = {sign, 31'd0};
      end else if (exp_sum >= 10'sd255) begin
         out = {sign, 8'hFF, 23'd0};
      end else if (exp_sum <= 10'sd0) begin
         out = {sign, 31'd0};
      end
   end

endmodule

module cordic_gain_accum #(
   parameter int MAX_ITER = 16,
   parameter int ITER_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ITER_W-1:0] n_iter,
   output logic              busy,
   output logic              done,
   output logic [31:0]       gain,
   output logic [ITER_W-1:0] n_used
);

   localparam logic [31:0]       ONE   = 32'h3F800000;
   localparam logic [ITER_W-1:0] MAX_N = ITER_W'(MAX_ITER);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state;
   logic [ITER_W-1:0] idx;
   logic [ITER_W-1:0] n_clamped;
   logic [31:0]       mult_out;
   logic              last_step;

   // cos(atan(2^-i)) = 1/sqrt(1+2^-2i), rounded to single. From i=12 upward,
   // every factor rounds to exactly 1.0.
   function automatic logic [31:0] rom_entry(input logic [ITER_W-1:0] i);
      case (int'(i))
         0:       rom_entry = 32'h3F3504F3;
         1:       rom_entry = 32'h3F64F92E;
         2:       rom_entry = 32'h3F785B42;
         3:       rom_entry = 32'h3F7E05EC;
         4:       rom_entry = 32'h3F7F8060;
         5:       rom_entry = 32'h3F7FE006;
         6:       rom_entry = 32'h3F7FF800;
         7:       rom_entry = 32'h3F7FFE00;
         8:       rom_entry = 32'h3F7FFF80;
         9:       rom_entry = 32'h3F7FFFE0;
         10:      rom_entry = 32'h3F7FFFF8;
         11:      rom_entry = 32'h3F7FFFFE;
         default: rom_entry = ONE;
      endcase
   endfunction

   Floating_Point_Multiplier u_mul (
      .out (mult_out),
      .a   (gain),
      .b   (rom_entry(idx))
   );

   assign n_clamped = (n_iter > MAX_N) ? MAX_N : n_iter;

   // Decide whether the multiply in this RUN cycle is the final one.
   always_comb begin
      last_step = (idx == n_used - 1'b1);
`ifdef GAIN_UNITY_SKIP_EN
      if (rom_entry(idx + 1'b1) == ONE) begin
         last_step = 1'b1;
      end
`endif
   end

   // Request FSM: accept in IDLE, accumulate one factor per RUN cycle, pulse done once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         n_used <= '0;
         gain   <= ONE;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  n_used <= n_clamped;
                  gain   <= ONE;
                  idx    <= '0;
                  busy   <= 1'b1;
                  if (n_clamped == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               gain <= mult_out;
               idx  <= idx + 1'b1;
               if (last_step) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
